// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg
//   Shared types and constants for the instruction-fetch / PC sequencer.
//   - fetch_state_t : sequencer state encoding (FETCH, WAIT, ISSUE, HALT)
//   - PCSRC_*       : controller next-PC select codes (2'b11 is reserved)
//   - NOP_INSTR     : addi x0,x0,0, held in the instruction register after reset
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/riscv_fetch_if.sv
// riscv_fetch_if
//   Instruction-memory request/grant/response bus.
//   imem_req    : fetch request, held until granted        (master -> slave)
//   imem_addr   : fetch address                            (master -> slave)
//   imem_gnt    : request accepted this cycle              (slave -> master)
//   imem_rvalid : read data valid                          (slave -> master)
//   imem_rdata  : fetched instruction word                 (slave -> master)
//   modport master is the fetch unit, modport slave is the memory.
interface riscv_fetch_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/riscv_next_pc.sv
// riscv_next_pc
//   Combinational next-PC mux with alignment check.
//   pc         : PC of the instruction being completed
//   pc_src     : select (00 pc+4, 01 pc_target, 10 JALR, 11 reserved -> pc+4)
//   pc_target  : pc + immediate (branch / JAL)
//   alu_result : JALR target, bit 0 is cleared here
//   next_pc    : selected next PC (modulo 2^XLEN)
//   misaligned : next_pc is not 4-byte aligned
module riscv_next_pc
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      PCSRC_PLUS4:  next_pc = pc_plus4;
      PCSRC_TARGET: next_pc = pc_target;
      // JALR target always has bit 0 forced low; bit 1 can still misalign it
      PCSRC_JALR:   next_pc = alu_result & ~XLEN'(1);
      default:      next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
//   Instruction fetch and PC sequencer feeding the core controller.
//   Fetches the word at pc, holds it until the datapath reports completion,
//   then advances or redirects according to the controller's pc_src.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   imem        : instruction-memory bus (riscv_fetch_if.master)
//   instr_valid : instr/fields/pc are valid for controller and datapath
//   instr       : held instruction; opcode/funct3/funct7 are slices of it
//   pc          : PC of the held instruction; pc_plus4 = pc + 4
//   exec_done   : one-cycle completion pulse, samples pc_src/pc_target/alu_result
//   fetch_err   : sticky, set when a redirect target is misaligned (unit halts)
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  riscv_fetch_if.master     imem,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  input  logic              exec_done,
  input  logic [1:0]        pc_src,
  input  logic [XLEN-1:0]   pc_target,
  input  logic [XLEN-1:0]   alu_result,
  output logic              fetch_err
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [31:0]     instr_reg, instr_next;
  logic            fetch_err_reg, fetch_err_next;

  logic [XLEN-1:0] sel_pc;
  logic            sel_misaligned;

  riscv_next_pc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pc         (pc_reg),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .alu_result (alu_result),
    .next_pc    (sel_pc),
    .misaligned (sel_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      instr_reg     <= NOP_INSTR;
      fetch_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      fetch_err_reg <= fetch_err_next;
    end
  end

  // Each state only looks at its own input (gnt in FETCH, rvalid in WAIT,
  // exec_done in ISSUE), so stray events elsewhere fall through unchanged.
  // In FETCH a simultaneous rvalid is simply not looked at.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    fetch_err_next = fetch_err_reg;
    unique case (state_reg)
      FETCH: begin
        if (imem.imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_next = imem.imem_rdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          if (sel_misaligned) begin
            // pc keeps pointing at the faulting instruction
            fetch_err_next = 1'b1;
            state_next     = HALT;
          end else begin
            pc_next    = sel_pc;
            state_next = FETCH;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // rst_n gates the request so nothing is presented while reset is held,
  // even though the state register already sits in FETCH.
  assign imem.imem_req  = rst_n && (state_reg == FETCH);
  assign imem.imem_addr = pc_reg;

  assign instr_valid = (state_reg == ISSUE);
  assign instr       = instr_reg;
  assign opcode      = instr_reg[6:0];
  assign funct3      = instr_reg[14:12];
  assign funct7      = instr_reg[31:25];
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + XLEN'(4);
  assign fetch_err   = fetch_err_reg;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit
//   Randomized scoreboard bench: a memory responder and a controller model
//   drive the unit; expected fetch addresses and issued PCs are queued by the
//   reference model, and a monitor pops and compares them as the unit shows them.
module tb_riscv_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        fetch_err;

  riscv_fetch_if #(.XLEN(XLEN)) imem_if ();

  riscv_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_if),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .exec_done   (exec_done),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .alu_result  (alu_result),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
  } op_t;

  op_t         dir_q[$];
  int          gnt_q[$];
  int          resp_q[$];
  logic [31:0] exp_fetch[$];
  logic [31:0] exp_issue[$];

  logic [31:0] m_pc;
  bit          m_halted;
  int          halt_age;
  int          n_tests;
  int          n_fail;
  int          n_issue;

  // Memory contents: address 0 holds addi x1,x0,5, everything else is a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5673;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next PC straight from the select rules.
  task automatic model_exec(input op_t op);
    logic [31:0] nxt;
    case (op.src)
      2'b01:   nxt = op.tgt;
      2'b10:   nxt = {op.alu[31:1], 1'b0};
      default: nxt = m_pc + 32'd4;
    endcase
    if ((nxt % 4) != 0) begin
      m_halted = 1'b1;
      halt_age = 0;
    end else begin
      m_pc = nxt;
      exp_fetch.push_back(nxt);
      exp_issue.push_back(nxt);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.src = 2'($urandom_range(3));
    o.tgt = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(7) == 0) o.tgt = 32'hFFFF_FFFC;
    if ($urandom_range(15) == 0) o.tgt = o.tgt | 32'($urandom_range(1, 3));
    o.alu = $urandom & 32'hFFFF_FFFD;
    if ($urandom_range(15) == 0) o.alu = o.alu | 32'h2;
    return o;
  endfunction

  task automatic do_reset(input int cyc);
    #2;
    rst_n = 1'b0;
    exp_fetch.delete();
    exp_issue.delete();
    m_pc     = RESET_PC;
    m_halted = 1'b0;
    halt_age = 0;
    exp_fetch.push_back(RESET_PC);
    exp_issue.push_back(RESET_PC);
    $display("[TB] reset for %0d cycles", cyc);
    repeat (cyc) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Instruction memory: variable grant and response latency, stray rvalid pulses.
  initial begin : mem_proc
    int          gcnt;
    int          pcnt;
    bit          pend;
    logic [31:0] paddr;
    gcnt = -1; pcnt = 0; pend = 1'b0; paddr = '0;
    imem_if.imem_gnt    = 1'b0;
    imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      imem_if.imem_gnt    = 1'b0;
      imem_if.imem_rvalid = 1'b0;
      imem_if.imem_rdata  = $urandom;
      if (pend) begin
        if (pcnt == 0) begin
          imem_if.imem_rvalid = 1'b1;
          imem_if.imem_rdata  = mem_word(paddr);
          pend = 1'b0;
        end else begin
          pcnt--;
        end
      end else begin
        if ($urandom_range(7) == 0) imem_if.imem_rvalid = 1'b1;
        if (imem_if.imem_req) begin
          if (gcnt < 0) gcnt = (gnt_q.size() > 0) ? gnt_q.pop_front() : int'($urandom_range(2));
          if (gcnt == 0) begin
            imem_if.imem_gnt = 1'b1;
            pend  = 1'b1;
            paddr = imem_if.imem_addr;
            pcnt  = (resp_q.size() > 0) ? resp_q.pop_front() : int'($urandom_range(3));
            gcnt  = -1;
          end else begin
            gcnt--;
          end
        end
      end
    end
  end

  // Controller: completes issued instructions, sends stray exec_done pulses.
  initial begin : ctrl_proc
    op_t op;
    bit  go;
    exec_done = 1'b0; pc_src = '0; pc_target = '0; alu_result = '0;
    forever begin
      @(posedge clk); #1;
      exec_done  = 1'b0;
      pc_src     = 2'($urandom_range(3));
      pc_target  = $urandom;
      alu_result = $urandom;
      go         = 1'b0;
      if (rst_n) begin
        if (m_halted) begin
          halt_age++;
          chk("halt_err", 32'(fetch_err), 32'd1);
          chk("halt_req", 32'(imem_if.imem_req), 32'd0);
          chk("halt_valid", 32'(instr_valid), 32'd0);
          if ($urandom_range(2) == 0) exec_done = 1'b1;
        end else if (instr_valid) begin
          if (dir_q.size() > 0) begin
            op = dir_q.pop_front();
            go = 1'b1;
          end else if ($urandom_range(2) == 0) begin
            op = rand_op();
            go = 1'b1;
          end
          if (go) begin
            pc_src     = op.src;
            pc_target  = op.tgt;
            alu_result = op.alu;
            exec_done  = 1'b1;
            model_exec(op);
          end
        end else if ($urandom_range(7) == 0) begin
          exec_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the unit grants a fetch or issues.
  initial begin : mon_proc
    bit          prev_valid;
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;
    prev_valid = 1'b0; prev_wait = 1'b0; prev_addr = '0;
    cur_pc = '0; cur_instr = NOP_INSTR;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req", 32'(imem_if.imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_pc", pc, RESET_PC);
        prev_valid = 1'b0;
        prev_wait  = 1'b0;
      end else begin
        if (prev_wait) begin
          chk("req_hold", 32'(imem_if.imem_req), 32'd1);
          chk("addr_hold", imem_if.imem_addr, prev_addr);
        end
        if (imem_if.imem_req && imem_if.imem_gnt) begin
          if (exp_fetch.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL fetch_unexpected: got addr %h, required no fetch", imem_if.imem_addr);
          end else begin
            chk("fetch_addr", imem_if.imem_addr, exp_fetch.pop_front());
          end
        end
        prev_wait = imem_if.imem_req && !imem_if.imem_gnt;
        prev_addr = imem_if.imem_addr;
        if (instr_valid && !prev_valid) begin
          if (exp_issue.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL issue_unexpected: got pc %h, required no issue", pc);
          end else begin
            cur_pc    = exp_issue.pop_front();
            cur_instr = mem_word(cur_pc);
            n_issue++;
            $display("[TB] issue pc=%h instr=%h", cur_pc, cur_instr);
            chk("issue_err", 32'(fetch_err), 32'd0);
          end
        end
        if (instr_valid) begin
          chk("instr", instr, cur_instr);
          chk("pc", pc, cur_pc);
          chk("pc_plus4", pc_plus4, cur_pc + 32'd4);
          chk("opcode", 32'(opcode), 32'(cur_instr[6:0]));
          chk("funct3", 32'(funct3), 32'(cur_instr[14:12]));
          chk("funct7", 32'(funct7), 32'(cur_instr[31:25]));
        end
        prev_valid = instr_valid;
      end
    end
  end

  initial begin : main_proc
    n_tests = 0; n_fail = 0; n_issue = 0;
    m_pc = RESET_PC; m_halted = 1'b0; halt_age = 0;

    // zero-wait first fetch, then a grant withheld for 3 cycles
    gnt_q.push_back(0);
    gnt_q.push_back(3);
    resp_q.push_back(0);
    dir_q.push_back('{src: 2'b00, tgt: 32'h0,         alu: 32'h0});    // 0   -> 4
    dir_q.push_back('{src: 2'b00, tgt: 32'h0,         alu: 32'h0});    // 4   -> 8
    dir_q.push_back('{src: 2'b01, tgt: 32'h40,        alu: 32'h0});    // 8   -> 40
    dir_q.push_back('{src: 2'b10, tgt: 32'h0,         alu: 32'h101});  // 40  -> 100
    dir_q.push_back('{src: 2'b01, tgt: 32'h42,        alu: 32'h0});    // 100 -> halt
    dir_q.push_back('{src: 2'b01, tgt: 32'hFFFF_FFFC, alu: 32'h0});    // 0   -> FFFFFFFC
    dir_q.push_back('{src: 2'b00, tgt: 32'h0,         alu: 32'h0});    // wraps to 0
    dir_q.push_back('{src: 2'b11, tgt: 32'h80,        alu: 32'h200});  // reserved -> 4

    do_reset(3);

    for (int t = 0; t < 500 && !m_halted; t++) @(posedge clk);
    chk("dir_halt_seen", 32'(m_halted), 32'd1);
    repeat (8) @(posedge clk);
    do_reset(2);

    for (int t = 0; t < 500 && dir_q.size() != 0; t++) @(negedge clk);
    chk("dir_drained", 32'(dir_q.size()), 32'd0);
    resp_q.push_back(5);
    @(negedge clk);
    for (int t = 0; t < 100 && !(imem_if.imem_req && imem_if.imem_gnt); t++) @(negedge clk);
    chk("wait_grant_seen", 32'(imem_if.imem_req && imem_if.imem_gnt), 32'd1);
    @(posedge clk);
    do_reset(2);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (m_halted && halt_age > 6) do_reset(2);
      else if ($urandom_range(499) == 0) do_reset(int'($urandom_range(1, 3)));
    end

    chk("progress", 32'(n_issue >= 40), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
